// File: rtl/sram_like_arbiter.sv
// rtl/sram_like_arbiter.sv - arbiter sharing one sram-like port between inst and data requesters
//
// Purpose:
//   Grants a single memory/bridge sram-like port to either the CPU inst or data
//   requester, one outstanding transaction at a time (IDLE -> ADDR -> DATA).
//   Data wins a simultaneous request unless inst has waited through STARVE_LIM
//   consecutive data grants, in which case inst is forced to win.
//
// Ports:
//   clk, rstn                      clock (rising edge), asynchronous active-low reset
//   inst_req/wr/size/addr          inst request fields, req held until inst_addr_ok
//   inst_addr_ok/data_ok/rdata     inst handshake pulses and read data
//   data_req/wr/size/addr/wdata    data request fields, req held until data_addr_ok
//   data_addr_ok/data_ok/rdata     data handshake pulses and read data
//   bus_req/wr/size/addr/wdata     registered shared-port request
//   bus_rdata/addr_ok/data_ok      shared-port response

module sram_like_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_LIM = 4
) (
    input  logic              clk,
    input  logic              rstn,

    input  logic              inst_req,
    input  logic              inst_wr,
    input  logic [1:0]        inst_size,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [DATA_W-1:0] inst_rdata,

    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata,

    output logic              bus_req,
    output logic              bus_wr,
    output logic [1:0]        bus_size,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_addr_ok,
    input  logic              bus_data_ok
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam logic       OWN_INST = 1'b0;
    localparam logic       OWN_DATA = 1'b1;
    localparam logic [3:0] LIM      = 4'(STARVE_LIM);

    state_t              state_q;
    logic                owner_q;
    logic [3:0]          starve_q;
    logic                bus_req_q;
    logic                bus_wr_q;
    logic [1:0]          bus_size_q;
    logic [ADDR_W-1:0]   bus_addr_q;
    logic [DATA_W-1:0]   bus_wdata_q;

    logic any_req;
    logic pick_data;
    logic addr_hs;
    logic data_hs;

    assign any_req   = inst_req | data_req;
    // Data wins a tie unless inst has been passed over STARVE_LIM times in a row.
    assign pick_data = data_req & ~(inst_req & (starve_q == LIM));
    // Handshakes only count in the phase that expects them; strays are dropped.
    assign addr_hs   = (state_q == ADDR) & bus_addr_ok;
    assign data_hs   = (state_q == DATA) & bus_data_ok;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            owner_q     <= OWN_INST;
            starve_q    <= '0;
            bus_req_q   <= 1'b0;
            bus_wr_q    <= 1'b0;
            bus_size_q  <= '0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        state_q   <= ADDR;
                        bus_req_q <= 1'b1;
                        if (pick_data) begin
                            owner_q     <= OWN_DATA;
                            bus_wr_q    <= data_wr;
                            bus_size_q  <= data_size;
                            bus_addr_q  <= data_addr;
                            bus_wdata_q <= data_wr ? data_wdata : '0;
                            // Only a grant that leaves inst waiting counts toward starvation.
                            if (!inst_req) begin
                                starve_q <= '0;
                            end else if (starve_q != LIM) begin
                                starve_q <= starve_q + 4'd1;
                            end
                        end else begin
                            owner_q     <= OWN_INST;
                            bus_wr_q    <= inst_wr;
                            bus_size_q  <= inst_size;
                            bus_addr_q  <= inst_addr;
                            bus_wdata_q <= '0;
                            starve_q    <= '0;
                        end
                    end else begin
                        starve_q <= '0;
                    end
                end
                ADDR: begin
                    if (bus_addr_ok) begin
                        bus_req_q <= 1'b0;
                        state_q   <= DATA;
                    end
                end
                DATA: begin
                    if (bus_data_ok) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    bus_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus_req   = bus_req_q;
    assign bus_wr    = bus_wr_q;
    assign bus_size  = bus_size_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;

    assign inst_addr_ok = addr_hs & (owner_q == OWN_INST);
    assign data_addr_ok = addr_hs & (owner_q == OWN_DATA);
    assign inst_data_ok = data_hs & (owner_q == OWN_INST);
    assign data_data_ok = data_hs & (owner_q == OWN_DATA);

    // Read data is forced to zero outside the owner's data_ok cycle.
    assign inst_rdata = inst_data_ok ? bus_rdata : '0;
    assign data_rdata = data_data_ok ? bus_rdata : '0;

endmodule

// File: tb/tb_sram_like_arbiter.sv
// tb/tb_sram_like_arbiter.sv - randomized self-checking bench for sram_like_arbiter

module tb_sram_like_arbiter;

    localparam int LIM = 4;

    logic        clk = 1'b0;
    logic        rstn;
    logic        inst_req, inst_wr;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        bus_req, bus_wr;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic        bus_addr_ok, bus_data_ok;

    sram_like_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIM(LIM)) dut (
        .clk(clk), .rstn(rstn),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .data_rdata(data_rdata),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_addr_ok(bus_addr_ok),
        .bus_data_ok(bus_data_ok)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: transaction phase (0 free, 1 awaiting address ack,
    // 2 awaiting data), owner of the open transaction, consecutive data wins.
    int          m_phase;
    logic        m_own;
    int          m_starve;
    logic        e_wr;
    logic [1:0]  e_size;
    logic [31:0] e_addr, e_wdata;

    logic drop_i, drop_d;
    bit   rand_fields;
    int   req_pct, addr_pct, data_pct;
    int   cyc, iao_cyc, ido_cyc, d_pulses;
    int   owners[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock cycle: entered at posedge+1, drives inputs, checks at the
    // falling edge, advances the model, returns at the next posedge+1.
    task automatic step();
        logic e_iao, e_dao, e_ido, e_ddo, win_d;
        if (drop_i) begin inst_req = 1'b0; drop_i = 1'b0; end
        if (drop_d) begin data_req = 1'b0; drop_d = 1'b0; end
        if (rand_fields) begin
            inst_size  = 2'($urandom_range(2));
            inst_addr  = $urandom;
            data_wr    = 1'($urandom_range(1));
            data_size  = 2'($urandom_range(2));
            data_addr  = $urandom;
            data_wdata = $urandom;
        end
        if (!inst_req && int'($urandom_range(99)) < req_pct) inst_req = 1'b1;
        if (!data_req && int'($urandom_range(99)) < req_pct) data_req = 1'b1;
        bus_addr_ok = int'($urandom_range(99)) < addr_pct;
        bus_data_ok = int'($urandom_range(99)) < data_pct;
        bus_rdata   = $urandom;
        #4;
        cyc++;

        e_iao = (m_phase == 1) && !m_own && bus_addr_ok;
        e_dao = (m_phase == 1) &&  m_own && bus_addr_ok;
        e_ido = (m_phase == 2) && !m_own && bus_data_ok;
        e_ddo = (m_phase == 2) &&  m_own && bus_data_ok;
        check("bus_req", bus_req, m_phase == 1);
        if (m_phase == 1) begin
            check("bus_wr", bus_wr, e_wr);
            check("bus_size", bus_size, e_size);
            check("bus_addr", bus_addr, e_addr);
            check("bus_wdata", bus_wdata, e_wdata);
        end
        check("inst_addr_ok", inst_addr_ok, e_iao);
        check("data_addr_ok", data_addr_ok, e_dao);
        check("inst_data_ok", inst_data_ok, e_ido);
        check("data_data_ok", data_data_ok, e_ddo);
        check("inst_rdata", inst_rdata, e_ido ? bus_rdata : 32'h0);
        check("data_rdata", data_rdata, e_ddo ? bus_rdata : 32'h0);

        if (inst_addr_ok) begin owners.push_back(0); iao_cyc = cyc; end
        if (data_addr_ok) owners.push_back(1);
        if (inst_data_ok) ido_cyc = cyc;
        if (data_addr_ok || data_data_ok) d_pulses++;

        case (m_phase)
            0: begin
                if (inst_req || data_req) begin
                    win_d = data_req && !(inst_req && m_starve == LIM);
                    if (win_d && inst_req) m_starve = (m_starve + 1 > LIM) ? LIM : m_starve + 1;
                    else m_starve = 0;
                    m_own   = win_d;
                    e_wr    = win_d ? data_wr : inst_wr;
                    e_size  = win_d ? data_size : inst_size;
                    e_addr  = win_d ? data_addr : inst_addr;
                    e_wdata = (win_d && data_wr) ? data_wdata : 32'h0;
                    m_phase = 1;
                end else begin
                    m_starve = 0;
                end
            end
            1: if (bus_addr_ok) begin
                m_phase = 2;
                if (m_own) drop_d = 1'b1; else drop_i = 1'b1;
            end
            default: if (bus_data_ok) m_phase = 0;
        endcase
        @(posedge clk);
        #1;
    endtask

    int exp3[11] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 1};

    initial begin
        rstn = 1'b0;
        inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_addr = 0;
        data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wdata = 0;
        bus_addr_ok = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'h1234_5678;
        drop_i = 0; drop_d = 0; m_phase = 0; m_own = 0; m_starve = 0;
        e_wr = 0; e_size = 0; e_addr = 0; e_wdata = 0;
        rand_fields = 0; req_pct = 0; addr_pct = 100; data_pct = 100;
        cyc = 0; iao_cyc = -1; ido_cyc = -1; d_pulses = 0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_bus_req", bus_req, 0);
        check("rst_bus_wr", bus_wr, 0);
        check("rst_bus_size", bus_size, 0);
        check("rst_bus_addr", bus_addr, 0);
        check("rst_bus_wdata", bus_wdata, 0);
        check("rst_inst_addr_ok", inst_addr_ok, 0);
        check("rst_inst_data_ok", inst_data_ok, 0);
        check("rst_data_addr_ok", data_addr_ok, 0);
        check("rst_data_data_ok", data_data_ok, 0);
        check("rst_inst_rdata", inst_rdata, 0);
        check("rst_data_rdata", data_rdata, 0);
        rstn = 1'b1;

        // T1: inst only, zero-wait slave
        inst_addr = 32'hBFC0_0000; inst_size = 2'd2; inst_req = 1'b1;
        begin
            int c0;
            c0 = cyc;
            repeat (4) step();
            check("t1_addr_ok_cycle", iao_cyc - c0, 2);
            check("t1_data_ok_cycle", ido_cyc - c0, 3);
            check("t1_data_pulses", d_pulses, 0);
        end

        // T2: simultaneous inst and data store, data first
        owners.delete();
        data_wr = 1'b1; data_size = 2'd2; data_addr = 32'h8000_0010; data_wdata = 32'hDEAD_BEEF;
        inst_req = 1'b1; data_req = 1'b1;
        repeat (7) step();
        check("t2_grants", owners.size(), 2);
        if (owners.size() >= 2) begin
            check("t2_first_data", owners[0], 1);
            check("t2_second_inst", owners[1], 0);
        end

        // T3: both requesters continuously busy, starvation guard
        owners.delete();
        rand_fields = 1; req_pct = 100;
        repeat (33) step();
        check("t3_grants", owners.size(), 11);
        for (int k = 0; k < 11; k++)
            if (owners.size() > k) check($sformatf("t3_order%0d", k), owners[k], exp3[k]);

        // T4/T5: random traffic with slow and spurious slave handshakes
        req_pct = 30; addr_pct = 35; data_pct = 35;
        repeat (3000) step();

        // T6: reset during DATA
        req_pct = 0; addr_pct = 100; data_pct = 100;
        for (int i = 0; i < 50 && !(m_phase == 0 && !inst_req && !data_req); i++) step();
        check("t6_drain", (m_phase == 0 && !inst_req && !data_req), 1);
        step();
        rand_fields = 0; data_wr = 1'b0; data_pct = 0;
        inst_addr = 32'hBFC0_0100; inst_req = 1'b1; data_req = 1'b1;
        step();
        step();
        check("t6_in_data", (m_phase == 2 && m_own), 1);
        data_req = 1'b0; drop_d = 1'b0;
        bus_data_ok = 1'b1; bus_rdata = 32'hCAFE_F00D;
        rstn = 1'b0;
        #1;
        check("t6_rst_data_ok", data_data_ok, 0);
        check("t6_rst_data_rdata", data_rdata, 0);
        check("t6_rst_bus_req", bus_req, 0);
        check("t6_rst_bus_addr", bus_addr, 0);
        m_phase = 0; m_starve = 0; drop_i = 0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        owners.delete();
        data_pct = 100;
        repeat (4) step();
        check("t6_regrants", owners.size(), 1);
        if (owners.size() >= 1) check("t6_regrant_inst", owners[0], 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
